// File: rtl/arm_pll_pkg.sv
// Shared definitions for the PLL scale-counter reconfiguration front-end:
// mode encodings, ASCII mode names, FSM states and power-up field defaults.
package arm_pll_pkg;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_BYPASS = 2'd1;
    localparam logic [1:0] MODE_EVEN   = 2'd2;
    localparam logic [1:0] MODE_ODD    = 2'd3;

    localparam logic [31:0] DEF_FIELD = 32'd1;
    localparam logic [1:0]  DEF_MODE  = MODE_BYPASS;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_CHECK,
        S_HOLD
    } state_t;

    function automatic logic [47:0] mode_ascii(input logic [1:0] m);
        logic [47:0] s;
        case (m)
            MODE_OFF:    s = "   off";
            MODE_BYPASS: s = "bypass";
            MODE_EVEN:   s = "  even";
            default:     s = "   odd";
        endcase
        return s;
    endfunction

endpackage

// File: rtl/arm_cntr_shadow.sv
// Per-counter field registers (high/low/initial/mode) with async reset to
// the power-up defaults and a single-cycle write-enable load port.
module arm_cntr_shadow
    import arm_pll_pkg::*;
#(
    parameter int unsigned CNTR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [CNTR_W-1:0] high_in,
    input  logic [CNTR_W-1:0] low_in,
    input  logic [CNTR_W-1:0] init_in,
    input  logic [1:0]        mode_in,
    output logic [31:0]       high,
    output logic [31:0]       low,
    output logic [31:0]       init,
    output logic [47:0]       mode
);

    logic [1:0] mode_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high   <= DEF_FIELD;
            low    <= DEF_FIELD;
            init   <= DEF_FIELD;
            mode_q <= DEF_MODE;
        end else if (we) begin
            high   <= 32'(high_in);
            low    <= 32'(low_in);
            init   <= 32'(init_in);
            mode_q <= mode_in;
        end
    end

    assign mode = mode_ascii(mode_q);

endmodule

// File: rtl/arm_cntr_reconfig.sv
// Reconfiguration front-end for the PLL scale-down counters: validates one
// update request at a time and applies it while the target counter is in reset.
module arm_cntr_reconfig
    import arm_pll_pkg::*;
#(
    parameter int unsigned NUM_CNTR = 6,
    parameter int unsigned CNTR_W   = 8,
    parameter int unsigned HOLD     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_sel,
    input  logic [CNTR_W-1:0]      cfg_high,
    input  logic [CNTR_W-1:0]      cfg_low,
    input  logic [CNTR_W-1:0]      cfg_phase,
    input  logic [1:0]             cfg_mode,
    output logic [NUM_CNTR*32-1:0] cntr_high,
    output logic [NUM_CNTR*32-1:0] cntr_low,
    output logic [NUM_CNTR*32-1:0] cntr_init,
    output logic [NUM_CNTR*48-1:0] cntr_mode,
    output logic [NUM_CNTR-1:0]    cntr_reset,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned CNT_W = $clog2(HOLD + 1);

    if (HOLD < 2) begin : g_bad_hold
        $error("arm_cntr_reconfig: HOLD must be at least 2");
    end
    if (NUM_CNTR < 1 || NUM_CNTR > 8) begin : g_bad_num
        $error("arm_cntr_reconfig: NUM_CNTR must be in 1..8");
    end
    if (CNTR_W < 1 || CNTR_W > 32) begin : g_bad_width
        $error("arm_cntr_reconfig: CNTR_W must be in 1..32");
    end

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [NUM_CNTR-1:0] rst_d, we;
    logic                done_d, err_d;
    logic                reject, first_hold;

    logic [2:0]          sel_q;
    logic [CNTR_W-1:0]   high_q, low_q, phase_q;
    logic [1:0]          mode_q;

    assign cfg_ready = (state == S_IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rst_d   = cntr_reset;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we      = '0;

        reject = (32'(sel_q) >= NUM_CNTR) || (phase_q == '0) ||
                 (((mode_q == MODE_EVEN) || (mode_q == MODE_ODD)) &&
                  ((high_q == '0) || (low_q == '0)));
        first_hold = (state == S_HOLD) && (cnt == CNT_W'(HOLD - 1));

        for (int unsigned i = 0; i < NUM_CNTR; i++) begin
            we[i] = first_hold && (sel_q == 3'(i));
        end

        case (state)
            // Counter starts at HOLD: resets drop at 1, ready follows one cycle later.
            S_INIT: begin
                if (cnt == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) rst_d = '0;
                end
            end
            S_IDLE: begin
                if (cfg_valid) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    for (int unsigned i = 0; i < NUM_CNTR; i++) begin
                        if (sel_q == 3'(i)) rst_d[i] = 1'b1;
                    end
                    cnt_d   = CNT_W'(HOLD - 1);
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    for (int unsigned i = 0; i < NUM_CNTR; i++) begin
                        if (sel_q == 3'(i)) rst_d[i] = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_INIT;
            cnt        <= CNT_W'(HOLD);
            cntr_reset <= '1;
            done       <= 1'b0;
            err        <= 1'b0;
            sel_q      <= '0;
            high_q     <= '0;
            low_q      <= '0;
            phase_q    <= '0;
            mode_q     <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cntr_reset <= rst_d;
            done       <= done_d;
            err        <= err_d;
            if (cfg_ready && cfg_valid) begin
                sel_q   <= cfg_sel;
                high_q  <= cfg_high;
                low_q   <= cfg_low;
                phase_q <= cfg_phase;
                mode_q  <= cfg_mode;
            end
        end
    end

    for (genvar g = 0; g < NUM_CNTR; g++) begin : g_shadow
        arm_cntr_shadow #(
            .CNTR_W(CNTR_W)
        ) u_shadow (
            .clk     (clk),
            .reset_n (reset_n),
            .we      (we[g]),
            .high_in (high_q),
            .low_in  (low_q),
            .init_in (phase_q),
            .mode_in (mode_q),
            .high    (cntr_high[32*g +: 32]),
            .low     (cntr_low[32*g +: 32]),
            .init    (cntr_init[32*g +: 32]),
            .mode    (cntr_mode[48*g +: 48])
        );
    end

endmodule

// File: doc/arm_cntr_reconfig.md
# arm_cntr_reconfig

Reconfiguration front-end for the PLL output scale-down counters (C0..C5). Sits directly upstream of the per-counter scale models and drives their `high`, `low`, `initial_value`, `mode` and `reset` inputs. It accepts one counter-update request at a time over a valid/ready handshake and validates it. Each update is applied safely: the target counter is held in reset while its fields change, then released.

## Interface
- `NUM_CNTR`, 6: number of scale counters driven; legal range 1..8.
- `CNTR_W`, 8: width of requested high/low/phase fields; outputs are zero-extended to 32 bits.
- `HOLD`, 4: cycles the target counter is held in reset per update; must be ≥2, enforced by an elaboration check.
- `clk`  in  1  single clock domain.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_valid`  in  1  request valid.
- `cfg_ready`  out  1  block can accept a request.
- `cfg_sel`  in  3  target counter index.
- `cfg_high`, `cfg_low`  in  CNTR_W  high/low half-periods.
- `cfg_phase`  in  CNTR_W  initial_value, in input rising edges before the first output edge.
- `cfg_mode`  in  2  0 = off, 1 = bypass, 2 = even, 3 = odd.
- `cntr_high`, `cntr_low`, `cntr_init`  out  NUM_CNTR*32  packed per-counter fields; counter i occupies bits [32i+31:32i].
- `cntr_mode`  out  NUM_CNTR*48  packed 6-char ASCII per counter: "   off", "bypass", "  even", "   odd".
- `cntr_reset`  out  NUM_CNTR  active-high reset to each counter.
- `done`  out  1  one-cycle pulse; update applied.
- `err`  out  1  one-cycle pulse; request rejected.

## Operation
- **FSM states:** INIT, IDLE, CHECK, HOLD.
- **Reset values (reset_n low):**
  - state = INIT; `cntr_reset` = all ones; `cfg_ready` = 0; `done` = 0; `err` = 0.
  - every counter: high = 1, low = 1, init = 1, mode = "bypass".
- **INIT:** hold all `cntr_reset` high for HOLD cycles after reset_n deasserts, then clear them all and go to IDLE.
- **IDLE:** `cfg_ready` = 1. On `cfg_valid` & `cfg_ready`, latch all cfg_* fields and go to CHECK. `cfg_valid` is ignored in every other state.
- **CHECK:** reject the request if any of these hold:
  - `cfg_sel` ≥ NUM_CNTR;
  - `cfg_phase` == 0;
  - mode even/odd with `cfg_high` == 0 or `cfg_low` == 0.
- **CHECK outcomes:**
  - Reject: pulse `err`, return to IDLE, leave all outputs unchanged.
  - Accept: set `cntr_reset[sel]`, load the hold counter with HOLD-1, go to HOLD.
- **HOLD:**
  - First cycle: write the latched fields into slice `sel`.
  - When the hold counter reaches 0: clear `cntr_reset[sel]`, pulse `done`, go to IDLE.
  - Otherwise decrement the hold counter.
- Only slice `sel` ever changes; all other `cntr_reset` bits and fields stay untouched.
- Off and bypass modes accept any high/low values; the values are stored but unused downstream.

## Timing
- Handshake sampled at edge E0. CHECK is evaluated at E1.
- **Reject:** `err` high during the cycle after E1; `cfg_ready` high in that same cycle.
- **Accept:**
  - `cntr_reset[sel]` rises after E1.
  - New fields are visible after E2, so they change only while the counter is in reset.
  - `cntr_reset[sel]` falls after E1+HOLD; `done` and `cfg_ready` are high in that same cycle.
  - Accept-to-done latency = HOLD+1 edges; minimum request spacing = HOLD+2 cycles.
- **Back-to-back:** a `cfg_valid` held high is accepted on the first cycle `cfg_ready` returns.
- **reset_n mid-operation:** the in-flight request is dropped with no `done`/`err`, all outputs return to reset values immediately, and the INIT sequence reruns.
- **Reset release:** `cfg_ready` first rises HOLD+1 cycles after reset_n rises.

## Structure
- **Shared package `arm_pll_pkg`:**
  - mode encoding localparams;
  - 2-bit-to-ASCII mode function;
  - FSM state enum;
  - default field constants.
- **Sub-module `arm_cntr_shadow`:** one per counter. Holds high/low/init/mode registers with async reset to defaults and a write-enable load port. Instantiated NUM_CNTR times via generate.

## Test plan
- **Power-up:** HOLD = 4, release reset_n → `cntr_reset` = 6'h3F for 4 cycles, then 0. `cfg_ready` rises 5 cycles after release. All slices read high 1, low 1, init 1, "bypass".
- **Program C2:** sel = 2, high = 3, low = 2, phase = 1, mode even →
  - `cntr_reset[2]` high 4 cycles; `cntr_high[95:64]` = 3;
  - `done` 5 edges after accept; no other slice changes;
  - attached counter output period = 5 input clocks.
- **Invalid select:** sel = 6 → `err` pulse one cycle after CHECK. `cntr_reset` stays 0 and all fields are unchanged.
- **Invalid odd request:** mode odd, high = 0 → `err`. Also phase = 0 with mode bypass → `err`.
- **Reset mid-HOLD:** reset_n low during the 2nd HOLD cycle → immediate defaults, no `done`, INIT reruns.
- **Held valid, two requests:** C0 then C5 with valid held high → second request accepted the cycle `cfg_ready` returns. Two `done` pulses 6 cycles apart; C1..C4 untouched.
